// File: rtl/transpose_buffer.sv
// 8x8 ping-pong transpose buffer: rows are written into one bank while the
// previously completed bank is read out one column per cycle.

module transpose_lane #(
    parameter int WIDTH = 12
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_wr_en,
    input  logic                  i_wr_bank,
    input  logic [7:0][WIDTH-1:0] i_wr_data,
    input  logic                  i_rd_en,
    input  logic                  i_rd_bank,
    input  logic [2:0]            i_rd_col,
    output logic [WIDTH-1:0]      o_data
);
    // One matrix row (both banks); lane K drives output row K of each column.
    logic [1:0][7:0][WIDTH-1:0] mem;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            mem    <= '0;
            o_data <= '0;
        end else begin
            if (i_wr_en)
                mem[i_wr_bank] <= i_wr_data;
            o_data <= i_rd_en ? mem[i_rd_bank][i_rd_col] : '0;
        end
    end
endmodule

module transpose_buffer #(
    parameter int WIDTH = 12
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_valid,
    input  logic signed [WIDTH-1:0] i_data0,
    input  logic signed [WIDTH-1:0] i_data1,
    input  logic signed [WIDTH-1:0] i_data2,
    input  logic signed [WIDTH-1:0] i_data3,
    input  logic signed [WIDTH-1:0] i_data4,
    input  logic signed [WIDTH-1:0] i_data5,
    input  logic signed [WIDTH-1:0] i_data6,
    input  logic signed [WIDTH-1:0] i_data7,
    output logic                    o_valid,
    output logic signed [WIDTH-1:0] o_data0,
    output logic signed [WIDTH-1:0] o_data1,
    output logic signed [WIDTH-1:0] o_data2,
    output logic signed [WIDTH-1:0] o_data3,
    output logic signed [WIDTH-1:0] o_data4,
    output logic signed [WIDTH-1:0] o_data5,
    output logic signed [WIDTH-1:0] o_data6,
    output logic signed [WIDTH-1:0] o_data7,
    output logic [2:0]              o_col,
    output logic                    o_last
);
    logic [7:0][WIDTH-1:0] wr_data;
    logic [7:0][WIDTH-1:0] lane_data;
    logic [2:0]            wr_row;
    logic                  wr_bank;
    logic                  rd_active;
    logic [2:0]            rd_col;
    logic                  blk_done;

    assign wr_data  = {i_data7, i_data6, i_data5, i_data4,
                       i_data3, i_data2, i_data1, i_data0};
    assign blk_done = i_valid && (wr_row == 3'd7);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_row    <= '0;
            wr_bank   <= 1'b0;
            rd_active <= 1'b0;
            rd_col    <= '0;
            o_valid   <= 1'b0;
            o_col     <= '0;
            o_last    <= 1'b0;
        end else begin
            if (i_valid)
                wr_row <= wr_row + 3'd1;
            if (blk_done)
                wr_bank <= ~wr_bank;
            // A block completing on the same edge as column 7 restarts the read.
            if (blk_done) begin
                rd_active <= 1'b1;
                rd_col    <= '0;
            end else if (rd_active) begin
                rd_col <= rd_col + 3'd1;
                if (rd_col == 3'd7)
                    rd_active <= 1'b0;
            end
            o_valid <= rd_active;
            o_col   <= rd_active ? rd_col : 3'd0;
            o_last  <= rd_active && (rd_col == 3'd7);
        end
    end

    // The read bank is always the one not being written.
    genvar k;
    generate
        for (k = 0; k < 8; k++) begin : g_lane
            transpose_lane #(.WIDTH(WIDTH)) u_lane (
                .i_clk     (i_clk),
                .i_rst     (i_rst),
                .i_wr_en   (i_valid && (wr_row == 3'(k))),
                .i_wr_bank (wr_bank),
                .i_wr_data (wr_data),
                .i_rd_en   (rd_active),
                .i_rd_bank (~wr_bank),
                .i_rd_col  (rd_col),
                .o_data    (lane_data[k])
            );
        end
    endgenerate

    assign o_data0 = lane_data[0];
    assign o_data1 = lane_data[1];
    assign o_data2 = lane_data[2];
    assign o_data3 = lane_data[3];
    assign o_data4 = lane_data[4];
    assign o_data5 = lane_data[5];
    assign o_data6 = lane_data[6];
    assign o_data7 = lane_data[7];
endmodule

// File: tb/tb_transpose_buffer.sv
// Bench for transpose_buffer: queue-based block model checked every cycle,
// plus literal spot checks on known columns.

module tb_transpose_buffer;
    localparam int W = 12;

    typedef struct packed {
        logic [2:0]        col;
        logic [7:0][W-1:0] d;
    } col_t;

    logic                i_clk = 1'b0;
    logic                i_rst = 1'b1;
    logic                i_valid = 1'b0;
    logic signed [W-1:0] din  [8];
    logic signed [W-1:0] dout [8];
    logic                o_valid, o_last;
    logic [2:0]          o_col;

    int checks = 0;
    int errors = 0;

    // model state
    int   part [8][8];
    int   nrows = 0;
    col_t q [$];
    col_t exp_c = '0;
    logic exp_valid = 1'b0;

    transpose_buffer #(.WIDTH(W)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid),
        .i_data0(din[0]), .i_data1(din[1]), .i_data2(din[2]), .i_data3(din[3]),
        .i_data4(din[4]), .i_data5(din[5]), .i_data6(din[6]), .i_data7(din[7]),
        .o_valid(o_valid),
        .o_data0(dout[0]), .o_data1(dout[1]), .o_data2(dout[2]), .o_data3(dout[3]),
        .o_data4(dout[4]), .o_data5(dout[5]), .o_data6(dout[6]), .o_data7(dout[7]),
        .o_col(o_col), .o_last(o_last)
    );

    always #5 i_clk = ~i_clk;

    task automatic model_reset();
        q.delete();
        nrows     = 0;
        exp_c     = '0;
        exp_valid = 1'b0;
    endtask

    // Output registered at this edge is the oldest pending column; a block
    // whose 8th row arrives now only becomes visible from the next edge.
    task automatic model_step();
        col_t e;
        if (i_rst) begin
            model_reset();
            return;
        end
        if (q.size() > 0) begin
            exp_c     = q.pop_front();
            exp_valid = 1'b1;
        end else begin
            exp_c     = '0;
            exp_valid = 1'b0;
        end
        if (i_valid) begin
            for (int c = 0; c < 8; c++) part[nrows][c] = int'(din[c]);
            nrows++;
            if (nrows == 8) begin
                for (int c = 0; c < 8; c++) begin
                    e.col = 3'(c);
                    for (int r = 0; r < 8; r++) e.d[r] = part[r][c][W-1:0];
                    q.push_back(e);
                end
                nrows = 0;
            end
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        model_step();
        #1;
    endtask

    task automatic set_row(input logic v, input int base, input int r);
        i_valid = v;
        for (int c = 0; c < 8; c++) din[c] = W'(base + 16 * r + c);
    endtask

    task automatic idle(input int n);
        i_valid = 1'b0;
        for (int c = 0; c < 8; c++) din[c] = '0;
        repeat (n) tick();
    endtask

    task automatic send_block(input int base);
        for (int r = 0; r < 8; r++) begin
            set_row(1'b1, base, r);
            tick();
        end
        i_valid = 1'b0;
    endtask

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    // Per-cycle comparison against the model
    always @(negedge i_clk) begin
        logic bad;
        logic exp_last;
        exp_last = exp_valid && (exp_c.col == 3'd7);
        bad = (o_valid !== exp_valid) || (o_col !== exp_c.col) || (o_last !== exp_last);
        for (int k = 0; k < 8; k++) if (dout[k] !== exp_c.d[k]) bad = 1'b1;
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL cycle_cmp t=%0t: got v=%b col=%0d last=%b d0=%0d d7=%0d expected v=%b col=%0d last=%b d0=%0d d7=%0d",
                     $time, o_valid, o_col, o_last, dout[0], dout[7],
                     exp_valid, exp_c.col, exp_last, $signed(exp_c.d[0]), $signed(exp_c.d[7]));
        end
    end

    initial begin
        bit found;
        for (int c = 0; c < 8; c++) din[c] = '0;
        repeat (3) tick();
        chk("reset_valid", int'(o_valid), 0);
        chk("reset_data0", int'(dout[0]), 0);
        i_rst = 1'b0;
        idle(2);

        // single contiguous block: column 0 one cycle after row 7
        send_block(0);
        chk("single_lat_valid", int'(o_valid), 0);
        idle(1);
        chk("single_col0_valid", int'(o_valid), 1);
        chk("single_col0_d3", int'(dout[3]), 48);
        chk("single_col0_d7", int'(dout[7]), 112);
        idle(5);
        chk("single_col5_d2", int'(dout[2]), 37);
        idle(2);
        chk("single_col7_last", int'(o_last), 1);
        chk("single_col7_d6", int'(dout[6]), 103);
        idle(1);
        chk("single_after_valid", int'(o_valid), 0);
        idle(3);

        // gapped rows
        for (int r = 0; r < 8; r++) begin
            set_row(1'b1, 0, r);
            tick();
            idle(1);
        end
        chk("gap_col0_d5", int'(dout[5]), 80);
        idle(10);

        // back-to-back: three blocks, 24 contiguous rows
        for (int b = 0; b < 3; b++)
            for (int r = 0; r < 8; r++) begin
                set_row(1'b1, 100 * b, r);
                tick();
            end
        i_valid = 1'b0;
        idle(10);

        // signed extremes
        for (int r = 0; r < 8; r++) begin
            i_valid = 1'b1;
            for (int c = 0; c < 8; c++) din[c] = (r % 2 == 0) ? -12'sd2048 : 12'sd2047;
            tick();
        end
        idle(1);
        chk("signed_d0", int'(dout[0]), -2048);
        chk("signed_d1", int'(dout[1]), 2047);
        idle(10);

        // reset after 5 rows, with rows offered during reset
        for (int r = 0; r < 5; r++) begin
            set_row(1'b1, 200, r);
            tick();
        end
        i_rst = 1'b1;
        set_row(1'b1, 300, 0);
        repeat (2) tick();
        i_rst = 1'b0;
        idle(3);
        send_block(50);
        idle(1);
        chk("rst_mid_col0_d1", int'(dout[1]), 66);
        idle(10);

        // reset during read at column 3
        send_block(7);
        found = 1'b0;
        for (int n = 0; n < 20 && !found; n++) begin
            tick();
            if (o_valid && o_col == 3'd3) found = 1'b1;
        end
        chk("rd_rst_reached_col3", int'(found), 1);
        i_rst = 1'b1;
        model_reset();
        #1;
        chk("rd_rst_valid", int'(o_valid), 0);
        chk("rd_rst_d3", int'(dout[3]), 0);
        tick();
        i_rst = 1'b0;
        idle(12);
        send_block(20);
        idle(1);
        chk("rd_rst_recover_d2", int'(dout[2]), 52);
        idle(10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/transpose_buffer.md
TRANSPOSE_BUFFER -- requirements
Module: transpose_buffer

Interface
REQ-001 SHALL have parameter WIDTH, default 12, meaning the signed coefficient width, which matches the 1-D DCT output width.
REQ-002 SHALL have port i_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port i_rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port i_valid, input, 1 bit: the input row on i_data0..i_data7 is valid this cycle.
REQ-005 SHALL have ports i_data0..i_data7, input, signed WIDTH each: one 1-D DCT output row, element index 0..7.
REQ-006 SHALL have port o_valid, output, 1 bit: o_data0..o_data7 carry a valid column this cycle.
REQ-007 SHALL have ports o_data0..o_data7, output, signed WIDTH each: one column of the transposed 8x8 block; o_dataK is row K.
REQ-008 SHALL have port o_col, output, 3 bits: index (0..7) of the column currently presented.
REQ-009 SHALL have port o_last, output, 1 bit: high together with o_valid when o_col==7.

Function
REQ-010 SHALL contain two 8x8 banks of WIDTH-bit registers (ping-pong): one write bank and one read bank.
REQ-011 SHALL hold a 3-bit write-row counter wr_row, a 1-bit bank select wr_bank, a read-active flag and a 3-bit read-column counter rd_col.
REQ-012 On each edge with i_valid=1, SHALL store i_dataC into bank[wr_bank][wr_row][C] for C=0..7, then increment wr_row modulo 8.
REQ-013 Cycles with i_valid=0 SHALL leave all bank contents and wr_row unchanged; input rows need not be contiguous.
REQ-014 On the edge that stores row 7, SHALL toggle wr_bank, set read-active, and set rd_col=0 for the just-filled bank.
REQ-015 While read-active, each edge SHALL register o_valid=1, o_col=rd_col, o_dataK=bank[rd_bank][K][rd_col] for K=0..7, o_last=(rd_col==7), and increment rd_col.
REQ-016 After presenting column 7, SHALL clear read-active, so o_valid is low on the following cycle unless a new block completed in the meantime.
REQ-017 Latency: column 0 SHALL appear on outputs registered at the edge immediately after the edge capturing row 7; columns 0..7 SHALL follow on 8 consecutive cycles with no gaps.
REQ-018 Reading bank X and writing bank ~X in the same cycle SHALL both proceed; no stall and no backpressure exist.
REQ-019 Since a block needs at least 8 valid rows, reading SHALL always finish before the read bank is rewritten; at i_valid held continuously high, output SHALL be gapless back-to-back blocks.
REQ-020 When o_valid=0, o_data*, o_col and o_last SHALL hold 0.
REQ-021 Data SHALL pass unmodified: no rounding, scaling or sign change, WIDTH bits in and out.

Reset
REQ-022 While i_rst=1, SHALL immediately force o_valid=0, o_last=0, o_col=0, o_data*=0, wr_row=0, wr_bank=0, read-active=0 and rd_col=0.
REQ-023 Bank contents SHALL be reset to 0.
REQ-024 Reset mid-block SHALL discard the partial block and any in-progress read; the first valid row after release SHALL be row 0 of bank 0.
REQ-025 Rows presented while i_rst=1 SHALL be ignored.

Verification
REQ-026 Single block: 8 contiguous rows with i_dataC=16*R+C (R=row) -> one cycle after row 7, 8 cycles of o_valid with o_dataK=16*K+o_col, o_col 0..7, o_last only on o_col=7.
REQ-027 Gapped input: same 8 rows with i_valid toggling 1/0 -> identical output sequence; first column one cycle after the 8th valid row.
REQ-028 Back-to-back: 24 rows at i_valid=1 continuously, block b values 100*b+16*R+C -> 24 consecutive o_valid cycles, blocks in order, no corruption from the concurrent write bank.
REQ-029 Signed extremes: rows alternating -2048 and 2047 -> outputs reproduce the exact values with sign preserved.
REQ-030 Reset mid-operation: assert i_rst after 5 rows, release, send a full block -> no o_valid from the partial block; the full block output is correct.
REQ-031 Reset during read: assert i_rst at o_col=3 -> o_valid=0 and outputs 0 immediately; nothing is emitted until a new 8-row block completes.
